// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types, constants and MRRS decode for the DMA read request scheduler
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } dma_state_e;

    localparam int PAGE_BYTES = 4096;
    localparam int MAX_REQ_DW = 1024;
    localparam int TAG_W      = 8;

    // Codes above 5 saturate at the 4 KB request size.
    function automatic logic [10:0] mrrs_to_dw(input logic [2:0] code);
        logic [10:0] dw;
        case (code)
            3'd0:    dw = 11'd32;
            3'd1:    dw = 11'd64;
            3'd2:    dw = 11'd128;
            3'd3:    dw = 11'd256;
            3'd4:    dw = 11'd512;
            default: dw = 11'(MAX_REQ_DW);
        endcase
        return dw;
    endfunction

endpackage

// File: rtl/dma_rd_req_sched_if.sv
// rtl/dma_rd_req_sched_if.sv - MRd request handshake and completion feedback bundle
interface dma_rd_req_sched_if;
    import dma_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic [9:0]       req_len;
    logic [TAG_W-1:0] req_tag;
    logic             cpl_done;
    logic [TAG_W-1:0] cpl_tag;

    modport master (
        output req_valid, req_addr, req_len, req_tag,
        input  req_ready, cpl_done, cpl_tag
    );

    modport slave (
        input  req_valid, req_addr, req_len, req_tag,
        output req_ready, cpl_done, cpl_tag
    );

endinterface

// File: rtl/dma_tag_pool.sv
// rtl/dma_tag_pool.sv - busy bitmap of outstanding read tags with lowest-free selection
module dma_tag_pool
    import dma_pkg::*;
#(
    parameter int P_TAG_NUM = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             alloc,
    input  logic [TAG_W-1:0] alloc_idx,
    input  logic             free,
    input  logic [TAG_W-1:0] free_tag,
    input  logic             flush,
    output logic             free_any,
    output logic [TAG_W-1:0] free_idx,
    output logic             all_free,
    output logic             freed
);

    logic [P_TAG_NUM-1:0] busy_q;
    logic [P_TAG_NUM-1:0] busy_d;
    logic [P_TAG_NUM-1:0] free_mask;
    logic [P_TAG_NUM-1:0] alloc_mask;

    // Out-of-range or idle tags produce no free_mask bit and are thus ignored.
    always_comb begin
        free_mask  = '0;
        alloc_mask = '0;
        for (int i = 0; i < P_TAG_NUM; i++) begin
            free_mask[i]  = free && (free_tag == TAG_W'(i)) && busy_q[i];
            alloc_mask[i] = alloc && (alloc_idx == TAG_W'(i));
        end
    end

    // Alloc is ORed after the free so a same-tag collision leaves the tag busy.
    always_comb begin
        busy_d = flush ? '0 : ((busy_q & ~free_mask) | alloc_mask);
    end

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = P_TAG_NUM - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_any = 1'b1;
                free_idx = TAG_W'(i);
            end
        end
    end

    // Reflects this cycle's completion so the drain can finish without an extra cycle.
    assign all_free = ((busy_q & ~free_mask) == '0);
    assign freed    = |free_mask;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/dma_rd_req_sched.sv
// rtl/dma_rd_req_sched.sv - splits a DMA read into MRRS/4KB-bounded MRd requests; watchdog under DMA_RD_TIMEOUT_EN
module dma_rd_req_sched
    import dma_pkg::*;
#(
    parameter int P_TAG_NUM = 4,
    parameter int P_TIMEOUT = 65535
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [2:0]                 cfg_max_read_request_size,
    input  logic                       dma_start,
    input  logic [31:0]                dma_addr,
    input  logic [21:0]                dma_len_dw,
    output logic                       dma_busy,
    output logic                       dma_done,
    output logic                       o_timeout,
    dma_rd_req_sched_if.master         req_if
);

    dma_state_e       state_q, state_d;
    logic [31:0]      cur_addr_q, cur_addr_d;
    logic [21:0]      rem_dw_q, rem_dw_d;
    logic [10:0]      chunk_q, chunk_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [9:0]       req_len_q, req_len_d;
    logic [TAG_W-1:0] req_tag_q, req_tag_d;
    logic             done_q, done_d;

    logic [10:0]      mrrs_dw;
    logic [10:0]      boundary_dw;
    logic [10:0]      min_rem_mrrs;
    logic [10:0]      chunk;
    logic             hs;
    logic             flush;
    logic             wd_fire;

    logic             free_any;
    logic [TAG_W-1:0] free_idx;
    logic             all_free;
    logic             freed;

    dma_tag_pool #(
        .P_TAG_NUM (P_TAG_NUM)
    ) u_tag_pool (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .alloc     (hs),
        .alloc_idx (req_tag_q),
        .free      (req_if.cpl_done),
        .free_tag  (req_if.cpl_tag),
        .flush     (flush),
        .free_any  (free_any),
        .free_idx  (free_idx),
        .all_free  (all_free),
        .freed     (freed)
    );

    assign hs = (state_q == ST_ISSUE) && req_if.req_ready;

    always_comb begin
        mrrs_dw      = mrrs_to_dw(cfg_max_read_request_size);
        boundary_dw  = 11'((13'(PAGE_BYTES) - {1'b0, cur_addr_q[11:0]}) >> 2);
        min_rem_mrrs = (rem_dw_q < {11'b0, mrrs_dw}) ? rem_dw_q[10:0] : mrrs_dw;
        chunk        = (min_rem_mrrs < boundary_dw) ? min_rem_mrrs : boundary_dw;
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        rem_dw_d   = rem_dw_q;
        chunk_d    = chunk_q;
        req_addr_d = req_addr_q;
        req_len_d  = req_len_q;
        req_tag_d  = req_tag_q;
        done_d     = 1'b0;
        flush      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dma_start) begin
                    cur_addr_d = dma_addr & 32'hFFFF_FFFC;
                    rem_dw_d   = dma_len_dw;
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                if (rem_dw_q == '0) begin
                    state_d = ST_WAIT;
                end else if (free_any) begin
                    chunk_d    = chunk;
                    req_addr_d = cur_addr_q;
                    req_len_d  = chunk[9:0];
                    req_tag_d  = free_idx;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (req_if.req_ready) begin
                    cur_addr_d = cur_addr_q + {19'b0, chunk_q, 2'b00};
                    rem_dw_d   = rem_dw_q - {11'b0, chunk_q};
                    state_d    = ST_CALC;
                end
            end
            ST_WAIT: begin
                if (all_free) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog abort overrides normal progress and suppresses dma_done.
        if (wd_fire) begin
            flush   = 1'b1;
            done_d  = 1'b0;
            state_d = ST_IDLE;
        end
    end

`ifdef DMA_RD_TIMEOUT_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;
    logic        wd_run;

    assign wd_run  = (state_q != ST_IDLE) && !freed && !hs && !all_free;
    assign wd_fire = wd_run && ((wd_cnt_q + 32'd1) == 32'(P_TIMEOUT));

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if ((state_q == ST_IDLE) || freed || hs) begin
            wd_cnt_d = '0;
        end else if (wd_run) begin
            wd_cnt_d = wd_cnt_q + 32'd1;
        end
        if ((state_q == ST_IDLE) && dma_start) begin
            timeout_d = 1'b0;
        end
        if (wd_fire) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign wd_fire   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            rem_dw_q   <= '0;
            chunk_q    <= '0;
            req_addr_q <= '0;
            req_len_q  <= '0;
            req_tag_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            rem_dw_q   <= rem_dw_d;
            chunk_q    <= chunk_d;
            req_addr_q <= req_addr_d;
            req_len_q  <= req_len_d;
            req_tag_q  <= req_tag_d;
            done_q     <= done_d;
        end
    end

    assign dma_busy         = (state_q != ST_IDLE);
    assign dma_done         = done_q;
    assign req_if.req_valid = (state_q == ST_ISSUE);
    assign req_if.req_addr  = req_addr_q;
    assign req_if.req_len   = req_len_q;
    assign req_if.req_tag   = req_tag_q;

endmodule

// File: tb/tb_dma_rd_req_sched.sv
// tb/tb_dma_rd_req_sched.sv - directed self-checking bench for dma_rd_req_sched
module tb_dma_rd_req_sched;
    import dma_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [2:0]  cfg_mrrs;
    logic        dma_start;
    logic [31:0] dma_addr;
    logic [21:0] dma_len_dw;
    logic        dma_busy;
    logic        dma_done;
    logic        o_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    dma_rd_req_sched_if rif ();

    dma_rd_req_sched #(
        .P_TAG_NUM (2),
        .P_TIMEOUT (100)
    ) dut (
        .i_clk                     (i_clk),
        .i_rst_n                   (i_rst_n),
        .cfg_max_read_request_size (cfg_mrrs),
        .dma_start                 (dma_start),
        .dma_addr                  (dma_addr),
        .dma_len_dw                (dma_len_dw),
        .dma_busy                  (dma_busy),
        .dma_done                  (dma_done),
        .o_timeout                 (o_timeout),
        .req_if                    (rif.master)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL sim_watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_req(input string tag, input logic [31:0] addr, input logic [9:0] len,
                             input logic [7:0] rtag);
        check({tag, "_valid"}, {31'b0, rif.req_valid}, 32'd1);
        check({tag, "_addr"},  rif.req_addr, addr);
        check({tag, "_len"},   {22'b0, rif.req_len}, {22'b0, len});
        check({tag, "_tag"},   {24'b0, rif.req_tag}, {24'b0, rtag});
    endtask

    task automatic start_dma(input logic [2:0] cfg, input logic [31:0] addr, input logic [21:0] len);
        cfg_mrrs   = cfg;
        dma_addr   = addr;
        dma_len_dw = len;
        dma_start  = 1'b1;
        tick();
        dma_start  = 1'b0;
    endtask

    task automatic cpl_pulse(input logic [7:0] tag);
        rif.cpl_done = 1'b1;
        rif.cpl_tag  = tag;
        tick();
        rif.cpl_done = 1'b0;
    endtask

    initial begin
        i_rst_n       = 1'b0;
        cfg_mrrs      = 3'd0;
        dma_start     = 1'b0;
        dma_addr      = '0;
        dma_len_dw    = '0;
        rif.req_ready = 1'b0;
        rif.cpl_done  = 1'b0;
        rif.cpl_tag   = '0;
        tick();
        tick();

        check("rst_busy",  {31'b0, dma_busy}, 32'd0);
        check("rst_done",  {31'b0, dma_done}, 32'd0);
        check("rst_valid", {31'b0, rif.req_valid}, 32'd0);
        check("rst_addr",  rif.req_addr, 32'd0);
        check("rst_tmo",   {31'b0, o_timeout}, 32'd0);
        i_rst_n = 1'b1;
        tick();

        // Simple transfer: two 128 B requests
        rif.req_ready = 1'b1;
        start_dma(3'd0, 32'h0000_1000, 22'd64);
        check("t1_busy", {31'b0, dma_busy}, 32'd1);
        check("t1_calc_valid", {31'b0, rif.req_valid}, 32'd0);
        tick();
        check_req("t1_r0", 32'h0000_1000, 10'd32, 8'd0);
        tick();
        check("t1_gap_valid", {31'b0, rif.req_valid}, 32'd0);
        tick();
        check_req("t1_r1", 32'h0000_1080, 10'd32, 8'd1);
        tick();
        tick();
        check("t1_wait_busy", {31'b0, dma_busy}, 32'd1);
        check("t1_wait_done", {31'b0, dma_done}, 32'd0);
        cpl_pulse(8'd0);
        check("t1_half_done", {31'b0, dma_done}, 32'd0);
        cpl_pulse(8'd1);
        check("t1_done", {31'b0, dma_done}, 32'd1);
        check("t1_done_busy", {31'b0, dma_busy}, 32'd0);
        tick();
        check("t1_done_pulse", {31'b0, dma_done}, 32'd0);

        // 4 KB split with back-pressure, then a full 1024 DW chunk with code 7
        rif.req_ready = 1'b0;
        start_dma(3'd5, 32'h0000_0F80, 22'd1024);
        tick();
        check_req("t2_r0", 32'h0000_0F80, 10'd32, 8'd0);
        tick();
        check_req("t2_r0_hold", 32'h0000_0F80, 10'd32, 8'd0);
        rif.req_ready = 1'b1;
        tick();
        rif.req_ready = 1'b0;
        check("t2_gap_valid", {31'b0, rif.req_valid}, 32'd0);
        tick();
        check_req("t2_r1", 32'h0000_1000, 10'd992, 8'd1);
        rif.req_ready = 1'b1;
        tick();
        tick();
        cpl_pulse(8'd0);
        cpl_pulse(8'd1);
        check("t2_done", {31'b0, dma_done}, 32'd1);
        start_dma(3'd7, 32'h0000_2000, 22'd1024);
        tick();
        check_req("t2_full", 32'h0000_2000, 10'd0, 8'd0);
        tick();
        tick();
        cpl_pulse(8'd0);
        check("t2_full_done", {31'b0, dma_done}, 32'd1);

        // Tag exhaustion, bad tags, simultaneous handshake and completion
        start_dma(3'd0, 32'h0000_3000, 22'd128);
        tick();
        check_req("t3_r0", 32'h0000_3000, 10'd32, 8'd0);
        tick();
        tick();
        check_req("t3_r1", 32'h0000_3080, 10'd32, 8'd1);
        repeat (5) tick();
        check("t3_stall_valid", {31'b0, rif.req_valid}, 32'd0);
        check("t3_stall_busy", {31'b0, dma_busy}, 32'd1);
        cpl_pulse(8'd7);
        cpl_pulse(8'd2);
        tick();
        check("t3_badtag_valid", {31'b0, rif.req_valid}, 32'd0);
        cpl_pulse(8'd1);
        check("t3_free_calc", {31'b0, rif.req_valid}, 32'd0);
        tick();
        check_req("t3_r2", 32'h0000_3100, 10'd32, 8'd1);
        rif.cpl_done = 1'b1;
        rif.cpl_tag  = 8'd0;
        tick();
        rif.cpl_done = 1'b0;
        tick();
        check_req("t3_r3", 32'h0000_3180, 10'd32, 8'd0);
        tick();
        tick();
        cpl_pulse(8'd1);
        check("t3_one_left_done", {31'b0, dma_done}, 32'd0);
        cpl_pulse(8'd1);
        check("t3_idle_tag_done", {31'b0, dma_done}, 32'd0);
        check("t3_idle_tag_busy", {31'b0, dma_busy}, 32'd1);
        cpl_pulse(8'd0);
        check("t3_done", {31'b0, dma_done}, 32'd1);

        // Reset mid-ISSUE, restart, ignored start while busy
        rif.req_ready = 1'b0;
        start_dma(3'd0, 32'h0000_4000, 22'd64);
        tick();
        check("t4_pre_valid", {31'b0, rif.req_valid}, 32'd1);
        i_rst_n = 1'b0;
        tick();
        check("t4_rst_valid", {31'b0, rif.req_valid}, 32'd0);
        check("t4_rst_addr", rif.req_addr, 32'd0);
        check("t4_rst_len", {22'b0, rif.req_len}, 32'd0);
        check("t4_rst_busy", {31'b0, dma_busy}, 32'd0);
        i_rst_n = 1'b1;
        cpl_pulse(8'd0);
        start_dma(3'd0, 32'h0000_5000, 22'd32);
        tick();
        check_req("t4_r0", 32'h0000_5000, 10'd32, 8'd0);
        start_dma(3'd0, 32'h0000_6000, 22'd99);
        check_req("t4_r0_hold", 32'h0000_5000, 10'd32, 8'd0);
        rif.req_ready = 1'b1;
        tick();
        tick();
        cpl_pulse(8'd0);
        check("t4_done", {31'b0, dma_done}, 32'd1);
        repeat (3) tick();
        check("t4_no_restart_busy", {31'b0, dma_busy}, 32'd0);
        check("t4_no_restart_valid", {31'b0, rif.req_valid}, 32'd0);

        // Zero-length transfer
        start_dma(3'd0, 32'h0000_9000, 22'd0);
        check("t5_zero_busy", {31'b0, dma_busy}, 32'd1);
        tick();
        check("t5_zero_early", {31'b0, dma_done}, 32'd0);
        tick();
        check("t5_zero_done", {31'b0, dma_done}, 32'd1);
        check("t5_zero_idle", {31'b0, dma_busy}, 32'd0);

        // Watchdog
        start_dma(3'd0, 32'h0000_7000, 22'd32);
        tick();
        check_req("t6_r0", 32'h0000_7000, 10'd32, 8'd0);
        tick();
`ifdef DMA_RD_TIMEOUT_EN
        repeat (99) tick();
        check("t6_pre_tmo", {31'b0, o_timeout}, 32'd0);
        check("t6_pre_busy", {31'b0, dma_busy}, 32'd1);
        tick();
        check("t6_tmo", {31'b0, o_timeout}, 32'd1);
        check("t6_tmo_busy", {31'b0, dma_busy}, 32'd0);
        check("t6_tmo_done", {31'b0, dma_done}, 32'd0);
        tick();
        check("t6_tmo_sticky", {31'b0, o_timeout}, 32'd1);
        check("t6_tmo_nodone", {31'b0, dma_done}, 32'd0);
        start_dma(3'd0, 32'h0000_8000, 22'd32);
        check("t6_tmo_clear", {31'b0, o_timeout}, 32'd0);
        tick();
        check_req("t6_r1", 32'h0000_8000, 10'd32, 8'd0);
        tick();
        tick();
        cpl_pulse(8'd0);
        check("t6_done", {31'b0, dma_done}, 32'd1);
`else
        repeat (120) tick();
        check("t6_no_tmo", {31'b0, o_timeout}, 32'd0);
        check("t6_still_busy", {31'b0, dma_busy}, 32'd1);
        cpl_pulse(8'd0);
        check("t6_done", {31'b0, dma_done}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
